// File: rtl/interp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : interp_pkg
//  Description : Shared pixel type and edge-pad feeder state encoding for the
//                8-tap interpolator datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package interp_pkg;

    // One pixel as seen by the feeder and the interpolator
    typedef logic [7:0] pixel_t;

    // Feeder line phases: wait for p0, leading pad, line body, trailing pad
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } pad_state_e;

endpackage
`default_nettype wire

// File: rtl/edge_pad_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : edge_pad_feeder
//  Description : Replicates the first and last pixel of every input line so
//                the 8-tap interpolator sees PAD_L copies of p0, the line,
//                then PAD_R copies of p(N-1). Output beats are registered.
//                Optional macro EDGE_PAD_SOL_EN adds out_sol, a start-of-line
//                flag on the first leading beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_pad_feeder
    import interp_pkg::*;
#(
    parameter int LINE_LEN = 16,
    parameter int PAD_L    = 8,
    parameter int PAD_R    = 5
) (
    input  logic   clock,
    input  logic   reset,
    input  pixel_t in_data,
    input  logic   in_valid,
    output logic   in_ready,
    output pixel_t out_data,
    output logic   out_valid,
    input  logic   out_ready,
    output logic   out_last
`ifdef EDGE_PAD_SOL_EN
    ,
    output logic   out_sol
`endif
);

    localparam int c_pad_max = (PAD_L > PAD_R) ? PAD_L : PAD_R;
    localparam int c_cnt_w   = $clog2(c_pad_max + 1);
    localparam int c_pos_w   = $clog2(LINE_LEN);

    localparam logic [c_cnt_w-1:0] c_lead_last = c_cnt_w'(PAD_L - 1);
    localparam logic [c_cnt_w-1:0] c_tail_last = c_cnt_w'(PAD_R - 1);
    localparam logic [c_pos_w-1:0] c_pos_last  = c_pos_w'(LINE_LEN - 1);

    pad_state_e         r_state;
    pixel_t             r_hold;
    pixel_t             r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_pos_w-1:0] r_pos;
`ifdef EDGE_PAD_SOL_EN
    logic               r_sol;
`endif

    logic               w_out_xfer;
    logic               w_in_xfer;
    logic [c_cnt_w-1:0] w_cnt_next;

    assign w_out_xfer = r_out_valid && out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_cnt_next = r_cnt + 1'b1;

    // Input acceptance: p0 in IDLE (or on the final tail beat for back-to-back
    // lines), body pixels whenever the output register frees up this cycle
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            IDLE:    in_ready = 1'b1;
            BODY:    in_ready = (r_pos != c_pos_last) && (!r_out_valid || out_ready);
            TAIL:    in_ready = r_out_last && out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Line sequencer with the registered output beat held until it is taken
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_cnt       <= '0;
            r_pos       <= '0;
`ifdef EDGE_PAD_SOL_EN
            r_sol       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_xfer) begin
                        r_hold      <= in_data;
                        r_out_data  <= in_data;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= LEAD;
`ifdef EDGE_PAD_SOL_EN
                        r_sol       <= 1'b1;
`endif
                    end
                end
                LEAD: begin
                    if (w_out_xfer) begin
`ifdef EDGE_PAD_SOL_EN
                        r_sol <= 1'b0;
`endif
                        if (r_cnt == c_lead_last) begin
                            // p0 is still in the output register: it becomes body pixel 0
                            r_cnt   <= '0;
                            r_pos   <= '0;
                            r_state <= BODY;
                        end else begin
                            r_cnt <= w_cnt_next;
                        end
                    end
                end
                BODY: begin
                    if (w_in_xfer) begin
                        r_hold      <= in_data;
                        r_out_data  <= in_data;
                        r_out_valid <= 1'b1;
                        r_pos       <= r_pos + 1'b1;
                    end else if (w_out_xfer) begin
                        if (r_pos == c_pos_last) begin
                            // p(N-1) stays in the output register for the tail
                            r_cnt      <= '0;
                            r_out_last <= (PAD_R == 1);
                            r_state    <= TAIL;
                        end else begin
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                TAIL: begin
                    if (w_out_xfer) begin
                        if (r_out_last) begin
                            r_out_last <= 1'b0;
                            r_cnt      <= '0;
                            if (w_in_xfer) begin
                                r_hold     <= in_data;
                                r_out_data <= in_data;
                                r_state    <= LEAD;
`ifdef EDGE_PAD_SOL_EN
                                r_sol      <= 1'b1;
`endif
                            end else begin
                                r_out_valid <= 1'b0;
                                r_state     <= IDLE;
                            end
                        end else begin
                            r_cnt      <= w_cnt_next;
                            r_out_last <= (w_cnt_next == c_tail_last);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
`ifdef EDGE_PAD_SOL_EN
    assign out_sol   = r_sol;
`endif

endmodule
`default_nettype wire

// File: tb/tb_edge_pad_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_pad_feeder
//  Description : Scoreboard bench for edge_pad_feeder with default parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_pad_feeder;
    import interp_pkg::*;

    localparam int LINE_LEN = 16;
    localparam int PAD_L    = 8;
    localparam int PAD_R    = 5;

    logic   clock = 1'b0;
    logic   reset = 1'b1;
    pixel_t in_data = '0;
    logic   in_valid = 1'b0;
    logic   in_ready;
    pixel_t out_data;
    logic   out_valid;
    logic   out_ready = 1'b0;
    logic   out_last;
    logic   w_sol;

    edge_pad_feeder #(
        .LINE_LEN (LINE_LEN),
        .PAD_L    (PAD_L),
        .PAD_R    (PAD_R)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef EDGE_PAD_SOL_EN
        ,
        .out_sol   (w_sol)
`endif
    );

`ifndef EDGE_PAD_SOL_EN
    assign w_sol = 1'b0;
`endif

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       sol;
    } beat_t;

    beat_t  q_exp[$];
    pixel_t q_in[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     beats;
    int     idle;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // kind 0: 0,8,17..127   kind 1: 8..136   kind 2: all 255
    function automatic pixel_t pix(input int kind, input int i);
        case (kind)
            0:       return pixel_t'((i * 254 + (LINE_LEN - 1)) / (2 * (LINE_LEN - 1)));
            1:       return pixel_t'(8 + (i * 256 + (LINE_LEN - 1)) / (2 * (LINE_LEN - 1)));
            default: return 8'd255;
        endcase
    endfunction

    task automatic push_line(input int kind);
        beat_t b;
        for (int i = 0; i < LINE_LEN; i++) q_in.push_back(pix(kind, i));
        for (int j = 0; j < PAD_L + LINE_LEN + PAD_R; j++) begin
            if (j < PAD_L)                 b.data = pix(kind, 0);
            else if (j < PAD_L + LINE_LEN) b.data = pix(kind, j - PAD_L);
            else                           b.data = pix(kind, LINE_LEN - 1);
            b.last = (j == PAD_L + LINE_LEN + PAD_R - 1);
            b.sol  = (j == 0);
            q_exp.push_back(b);
        end
    endtask

    // Drive one cycle per loop pass at the negedge, sample #1 later
    task automatic run(input int ready_mode, input int gap_after, input int abort_after, input int budget);
        int    cyc      = 0;
        int    acc      = 0;
        int    gap_left = 0;
        bit    stalled  = 1'b0;
        bit    started  = 1'b0;
        beat_t held     = '0;
        beat_t e;
        beats = 0;
        idle  = 0;
        while (q_exp.size() > 0 && cyc < budget && !(abort_after > 0 && beats == abort_after)) begin
            out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 2 == 0);
            if (gap_left > 0) begin
                in_valid = 1'b0;
                gap_left--;
            end else begin
                in_valid = (q_in.size() > 0);
            end
            in_data = (q_in.size() > 0) ? q_in[0] : 8'd0;
            #1;
            if (stalled) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data",  32'(out_data),  32'(held.data));
                chk("stall_last",  32'(out_last),  32'(held.last));
`ifdef EDGE_PAD_SOL_EN
                chk("stall_sol",   32'(w_sol),     32'(held.sol));
`endif
            end
            if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (started && !out_valid) idle++;
            if (out_valid && out_ready) begin
                started = 1'b1;
                e = q_exp.pop_front();
                chk("beat_data", 32'(out_data), 32'(e.data));
                chk("beat_last", 32'(out_last), 32'(e.last));
`ifdef EDGE_PAD_SOL_EN
                chk("beat_sol",  32'(w_sol),    32'(e.sol));
`endif
                beats++;
            end
            stalled = out_valid && !out_ready;
            held    = {out_data, out_last, w_sol};
            if (in_valid && in_ready) begin
                void'(q_in.pop_front());
                acc++;
                if (acc == gap_after) gap_left = 3;
            end
            @(negedge clock);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clock);

        // Single line, downstream always ready
        push_line(0);
        run(0, -1, 0, 200);
        chk("l1_beats", 32'(beats), 32'd29);
        chk("l1_left",  32'(q_exp.size()), 32'd0);
        chk("l1_idle",  32'(idle), 32'd0);

        // Same line, downstream ready toggling every cycle
        push_line(0);
        run(1, -1, 0, 400);
        chk("stall_beats", 32'(beats), 32'd29);
        chk("stall_left",  32'(q_exp.size()), 32'd0);

        // Two lines back to back, no gap between out_last and next line
        push_line(0);
        push_line(1);
        run(0, -1, 0, 400);
        chk("b2b_beats", 32'(beats), 32'd58);
        chk("b2b_idle",  32'(idle), 32'd0);
        chk("b2b_left",  32'(q_exp.size()), 32'd0);

        // Input bubble of three cycles in the middle of the body
        push_line(1);
        run(0, 6, 0, 200);
        chk("gap_beats", 32'(beats), 32'd29);
        chk("gap_idle",  32'(idle), 32'd3);
        chk("gap_left",  32'(q_exp.size()), 32'd0);

        // Reset mid-line at beat 12, then a line of 255
        push_line(0);
        run(0, -1, 12, 200);
        chk("abort_beats", 32'(beats), 32'd12);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        q_exp.delete();
        q_in.delete();
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        @(negedge clock);
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clock);
        end
        out_ready = 1'b0;
        chk("abort_no_beats", 32'(seen), 32'd0);
        push_line(2);
        run(0, -1, 0, 200);
        chk("post_beats", 32'(beats), 32'd29);
        chk("post_left",  32'(q_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
